// File: rtl/pe_rs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pe_rs                                                        |
// | Description : Row-stationary processing element. Holds one filter row of   |
// |               KERNEL_SIZE weights, slides a KERNEL_SIZE-wide window over a |
// |               streamed ifmap row, computes each output serially (one MAC   |
// |               per cycle), adds the upstream partial sum and forwards the   |
// |               result down the psum chain. All streams are valid/ready.     |
// | Options     : PE_RS_SAT_EN - when defined, the final psum saturates to the |
// |               PSUM_WIDTH signed range; otherwise it wraps (keeps low bits).|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pe_rs #(
  parameter int IFM_WIDTH    = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int PSUM_WIDTH   = 16,
  parameter int KERNEL_SIZE  = 3,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic [LEN_WIDTH-1:0]    cfg_ofm_len,
  input  logic                    wgt_valid,
  output logic                    wgt_ready,
  input  logic [WEIGHT_WIDTH-1:0] wgt,
  input  logic                    ifm_valid,
  output logic                    ifm_ready,
  input  logic [IFM_WIDTH-1:0]    ifm,
  input  logic                    psum_in_valid,
  output logic                    psum_in_ready,
  input  logic [PSUM_WIDTH-1:0]   psum_in,
  output logic                    psum_out_valid,
  input  logic                    psum_out_ready,
  output logic [PSUM_WIDTH-1:0]   psum_out,
  output logic                    busy,
  output logic                    done
);

  localparam int PROD_W = IFM_WIDTH + WEIGHT_WIDTH;
  localparam int ACC_W  = PROD_W + $clog2(KERNEL_SIZE);
  localparam int IDX_W  = $clog2(KERNEL_SIZE);
  localparam int NEED_W = $clog2(KERNEL_SIZE + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(KERNEL_SIZE - 1);
  localparam logic [NEED_W-1:0] NEED_K   = NEED_W'(KERNEL_SIZE);
  localparam logic [NEED_W-1:0] NEED_ONE = NEED_W'(1);
`ifdef PE_RS_SAT_EN
  localparam int SUM_W = ((ACC_W > PSUM_WIDTH) ? ACC_W : PSUM_WIDTH) + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-PSUM_WIDTH+1){1'b0}}, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-PSUM_WIDTH+1){1'b1}}, {(PSUM_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_FILL   = 3'd2,
    S_MAC    = 3'd3,
    S_PSUM   = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  state_t                         state_q, state_d;
  logic signed [WEIGHT_WIDTH-1:0] w_q   [KERNEL_SIZE];
  logic signed [WEIGHT_WIDTH-1:0] w_d   [KERNEL_SIZE];
  logic signed [IFM_WIDTH-1:0]    win_q [KERNEL_SIZE];
  logic signed [IFM_WIDTH-1:0]    win_d [KERNEL_SIZE];
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  // idx walks the scratchpad during LOAD_W and is the MAC step t during MAC
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [NEED_W-1:0]              need_q, need_d;
  logic [LEN_WIDTH-1:0]           len_q, len_d;
  logic [LEN_WIDTH-1:0]           cnt_q, cnt_d;
  logic [PSUM_WIDTH-1:0]          psum_out_q, psum_out_d;
  logic                           done_q, done_d;

  logic signed [PROD_W-1:0]       w_ext, x_ext, prod;
  logic signed [ACC_W-1:0]        prod_ext, acc_base;
  logic [PSUM_WIDTH-1:0]          reduced;
`ifdef PE_RS_SAT_EN
  logic signed [SUM_W-1:0]        sum;
`endif

  // MAC product for the current step and the reduced final psum
  always_comb begin
    w_ext    = PROD_W'(w_q[idx_q]);
    x_ext    = PROD_W'(win_q[idx_q]);
    prod     = w_ext * x_ext;
    prod_ext = ACC_W'(prod);
    acc_base = (idx_q == '0) ? '0 : acc_q;
`ifdef PE_RS_SAT_EN
    sum = SUM_W'(acc_q) + SUM_W'($signed(psum_in));
    if (sum > SAT_MAX) begin
      reduced = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    end else if (sum < SAT_MIN) begin
      reduced = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
    end else begin
      reduced = sum[PSUM_WIDTH-1:0];
    end
`else
    // Wrapping only needs the low PSUM_WIDTH bits of the full sum
    reduced = PSUM_WIDTH'(acc_q) + psum_in;
`endif
  end

  // Next-state, datapath updates and state-decoded handshake outputs
  always_comb begin
    state_d        = state_q;
    w_d            = w_q;
    win_d          = win_q;
    acc_d          = acc_q;
    idx_d          = idx_q;
    need_d         = need_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    psum_out_d     = psum_out_q;
    done_d         = 1'b0;
    wgt_ready      = 1'b0;
    ifm_ready      = 1'b0;
    psum_in_ready  = 1'b0;
    psum_out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start && (cfg_ofm_len != '0)) begin
          len_d   = cfg_ofm_len;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        wgt_ready = 1'b1;
        if (wgt_valid) begin
          w_d[idx_q] = wgt;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            need_d  = NEED_K;
            state_d = S_FILL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FILL: begin
        ifm_ready = 1'b1;
        if (ifm_valid) begin
          for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
            win_d[j] = win_q[j+1];
          end
          win_d[KERNEL_SIZE-1] = ifm;
          if (need_q == NEED_ONE) begin
            idx_d   = '0;
            state_d = S_MAC;
          end else begin
            need_d = need_q - 1'b1;
          end
        end
      end
      S_MAC: begin
        acc_d = acc_base + prod_ext;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_PSUM;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_PSUM: begin
        psum_in_ready = 1'b1;
        if (psum_in_valid) begin
          psum_out_d = reduced;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        psum_out_valid = 1'b1;
        if (psum_out_ready) begin
          cnt_d = cnt_q + 1'b1;
          if ((cnt_q + 1'b1) == len_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            need_d  = NEED_ONE;
            state_d = S_FILL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      need_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      psum_out_q <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        w_q[i]   <= '0;
        win_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      need_q     <= need_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      psum_out_q <= psum_out_d;
      done_q     <= done_d;
      w_q        <= w_d;
      win_q      <= win_d;
    end
  end

  assign psum_out = psum_out_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire
